// File: rtl/countdown_timer_if.sv
// Load/control and status bundle between a config source (master) and the
// countdown timer (slave).
interface countdown_timer_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             auto_reload;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_value, auto_reload, pause, abort,
    input  load_ready, count, busy, done
  );

  modport slave (
    input  load_valid, load_value, auto_reload, pause, abort,
    output load_ready, count, busy, done
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter: accepts a start value, decrements once per clock and
// emits a one-cycle done pulse at zero, then stops or reloads.
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  countdown_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             done_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch below reads the pre-edge values of count_q/state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: done defaults low every edge; only a terminal edge re-asserts it,
      // which keeps it a single-cycle pulse without a separate clear path.
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.load_valid) begin
            if (bus.load_value != '0) begin
              count_q  <= bus.load_value;
              reload_q <= bus.load_value;
              state_q  <= RUN;
            end else begin
              count_q <= '0;
              done_q  <= 1'b1;
            end
          end
        end

        RUN: begin
          if (bus.abort) begin
            count_q <= '0;
            state_q <= IDLE;
          end else if (bus.pause) begin
            state_q <= HOLD;
          end else if (count_q > WIDTH'(1)) begin
            count_q <= count_q - WIDTH'(1);
          end else begin
            // Terminal edge: count_q is 1 here, RUN is never entered at 0.
            done_q <= 1'b1;
            if (bus.auto_reload) begin
              count_q <= reload_q;
            end else begin
              count_q <= '0;
              state_q <= IDLE;
            end
          end
        end

        HOLD: begin
          if (bus.abort) begin
            count_q <= '0;
            state_q <= IDLE;
          end else if (!bus.pause) begin
            state_q <= RUN;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // Status decoded from registered state only; no input-to-output paths.
  assign bus.load_ready = (state_q == IDLE);
  assign bus.busy       = (state_q == RUN) || (state_q == HOLD);
  assign bus.count      = count_q;
  assign bus.done       = done_q;

endmodule
